fifo_sync_param: RTL



---
 rtl/fifo_sync_param.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fifo_sync_param.sv
// fifo_sync_param
//   Parametrised single-clock FIFO used to stage keystream and plaintext words
//   between cipher datapath stages. DEPTH may be any integer >= 2. Pointers wrap
//   explicitly at DEPTH-1, so non-power-of-two depths need no spare entries.
//
// Build option:
//   FIFO_FWFT_EN  defined   -> first-word-fall-through read port
//                             (dout shows the head word while not empty,
//                              and read acknowledges that word)
//                 undefined -> registered read port (dout loaded one cycle
//                              after an accepted read, strobed by dout_valid)
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst           synchronous reset, active-high, has priority over everything
//   din           write data
//   write         write request
//   read          read request
//   clr_err       clears the sticky overflow/underflow flags
//   dout          read data
//   dout_valid    dout holds a newly read word (FWFT: dout holds the head word)
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         current occupancy, 0..DEPTH
//   overflow      sticky, set when a write is refused
//   underflow     sticky, set when a read is refused

module fifo_sync_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 36,
  parameter int AF_LEVEL = 32,
  parameter int AE_LEVEL = 4,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             write,
  input  logic             read,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_LEVEL);

  // Storage, deliberately not reset.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             rd_ok;
  logic             wr_ok;
  logic             full_w;
  logic             empty_w;

  // Explicit wrap keeps the pointer inside 0..DEPTH-1 for any DEPTH.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Status flags are pure decodes of the registered count, so they only move
  // on the edge that commits an accepted operation.
  assign full_w       = (count_q == DEPTH_C);
  assign empty_w      = (count_q == '0);
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A write into a full FIFO is still accepted when a read frees the head
  // slot in the same cycle; count then stays at DEPTH.
  always_comb begin
    rd_ok = read && !empty_w;
    wr_ok = write && (!full_w || rd_ok);
  end

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_ok) head_d = ptr_inc(head_q);
    if (rd_ok) tail_d = ptr_inc(tail_q);

    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A new error in the same cycle as clr_err wins, so nothing is lost.
    if (clr_err) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (write && !wr_ok) overflow_d  = 1'b1;
    if (read  && !rd_ok) underflow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Writes are blocked during reset so a burst cut by rst leaves no trace.
  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem_q[head_q] <= din;
  end

`ifdef FIFO_FWFT_EN

  // Head word is presented directly; read only acknowledges it. Contents are
  // meaningless while empty, which dout_valid reports.
  assign dout       = mem_q[tail_q];
  assign dout_valid = !empty_w;

`else

  logic [WIDTH-1:0] dout_q;
  logic             dout_valid_q;

  // One-cycle read latency; dout holds its last value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= rd_ok;
      if (rd_ok) dout_q <= mem_q[tail_q];
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

`endif

endmodule
